// File: rtl/regs_file_mp_if.sv
// Bus bundle for regs_file_mp: the two write ports, the packed read ports,
// the reservation port and the clear-engine control/status.
//
// Port summary (names as seen by the register file):
//   wa_*_i / wb_*_i   write ports A (ALU writeback) and B (load writeback)
//   rd_addr_i         NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data_o         NUM_RD packed read data,      port k at [k*DATA_W +: DATA_W]
//   rd_busy_o         busy bit of each addressed register
//   rsv_en_i/addr_i   mark a destination register busy
//   clr_req_i         start a sequential clear of the whole file
//   clr_busy_o        clear engine active
//   clr_done_o        one-cycle pulse when the clear completes
//   clr_state_o       clear FSM state, exposed for debug/observation
//
// Handshake semantics: there is no back-pressure anywhere on this bus.
// Every *_en_i / clr_req_i is a single-cycle qualifier sampled on the rising
// clock edge; a write or reservation presented while the clear engine is busy
// is dropped, never held or replayed.
//
// The parameters must match the ones given to regs_file_mp.
interface regs_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     wa_en_i;
  logic [ADDR_W-1:0]        wa_addr_i;
  logic [DATA_W-1:0]        wa_data_i;
  logic                     wb_en_i;
  logic [ADDR_W-1:0]        wb_addr_i;
  logic [DATA_W-1:0]        wb_data_i;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_busy_o;
  logic                     rsv_en_i;
  logic [ADDR_W-1:0]        rsv_addr_i;
  logic                     clr_req_i;
  logic                     clr_busy_o;
  logic                     clr_done_o;
  logic [1:0]               clr_state_o;

  // Decode / writeback side.
  modport master (
    output wa_en_i, wa_addr_i, wa_data_i,
    output wb_en_i, wb_addr_i, wb_data_i,
    output rd_addr_i, rsv_en_i, rsv_addr_i, clr_req_i,
    input  rd_data_o, rd_busy_o, clr_busy_o, clr_done_o, clr_state_o
  );

  // Register file side.
  modport slave (
    input  wa_en_i, wa_addr_i, wa_data_i,
    input  wb_en_i, wb_addr_i, wb_data_i,
    input  rd_addr_i, rsv_en_i, rsv_addr_i, clr_req_i,
    output rd_data_o, rd_busy_o, clr_busy_o, clr_done_o, clr_state_o
  );
endinterface

// File: rtl/regs_file_mp.sv
// Multi-port general-purpose register file for the rooth core.
//
// NUM_RD combinational read ports, two prioritised write ports (B beats A
// on the same address), optional write-to-read bypass, a per-register busy
// scoreboard and a sequential clear engine that zeroes one entry per cycle.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset; zeroes the array, the busy bits
//          and the clear FSM, and forces the read outputs to zero while low
//   bus    regs_file_mp_if.slave (write/read/reserve/clear signals)
module regs_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  regs_file_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;

  logic clearing;
  logic wa_acc, wb_acc, rsv_acc;

  assign clearing = (state_q == S_CLEAR);

  // A request is accepted only outside the clear sweep and never targets
  // the hardwired zero register.
  assign wa_acc  = bus.wa_en_i && !clearing &&
                   !((ZERO_REG != 0) && (bus.wa_addr_i == '0));
  assign wb_acc  = bus.wb_en_i && !clearing &&
                   !((ZERO_REG != 0) && (bus.wb_addr_i == '0));
  assign rsv_acc = bus.rsv_en_i && !clearing &&
                   !((ZERO_REG != 0) && (bus.rsv_addr_i == '0));

  // Clear FSM: IDLE -> CLEAR (DEPTH cycles, idx 0..DEPTH-1) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_req_i) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        // idx stops at DEPTH-1 instead of wrapping.
        if (idx_q == ADDR_W'(DEPTH - 1)) state_d = S_DONE;
        else                             idx_d   = idx_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Storage array. B is applied after A so it wins on a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clearing) begin
      mem_q[idx_q] <= '0;
    end else begin
      if (wa_acc) mem_q[bus.wa_addr_i] <= bus.wa_data_i;
      if (wb_acc) mem_q[bus.wb_addr_i] <= bus.wb_data_i;
    end
  end

  // Busy scoreboard. The reservation is applied last so a same-cycle
  // reserve and write to one register leaves it busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else if (clearing) begin
      busy_q[idx_q] <= 1'b0;
    end else begin
      if (wa_acc)  busy_q[bus.wa_addr_i]  <= 1'b0;
      if (wb_acc)  busy_q[bus.wb_addr_i]  <= 1'b0;
      if (rsv_acc) busy_q[bus.rsv_addr_i] <= 1'b1;
    end
  end

  // Combinational read ports. Bypass uses the accepted-write strobes, so a
  // write dropped during the clear sweep is never forwarded. Busy is not
  // bypassed: it always shows the registered scoreboard.
  logic [ADDR_W-1:0]        ra;
  logic [DATA_W-1:0]        rdat;
  logic                     rbsy;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  always_comb begin
    ra        = '0;
    rdat      = '0;
    rbsy      = 1'b0;
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra   = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
      rdat = mem_q[ra];
      rbsy = busy_q[ra];
      if (BYPASS != 0) begin
        if (wa_acc && (bus.wa_addr_i == ra)) rdat = bus.wa_data_i;
        if (wb_acc && (bus.wb_addr_i == ra)) rdat = bus.wb_data_i;
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdat = '0;
        rbsy = 1'b0;
      end
      if (!rst_n) begin
        rdat = '0;
        rbsy = 1'b0;
      end
      rd_data_c[k*DATA_W +: DATA_W] = rdat;
      rd_busy_c[k]                  = rbsy;
    end
  end

  assign bus.rd_data_o   = rd_data_c;
  assign bus.rd_busy_o   = rd_busy_c;
  assign bus.clr_busy_o  = clearing;
  assign bus.clr_done_o  = (state_q == S_DONE);
  assign bus.clr_state_o = state_q;

endmodule

// File: tb/tb_regs_file_mp.sv
// Directed bench for regs_file_mp. Three instances share clock and reset:
//   dut_a  defaults (BYPASS=1)
//   dut_b  BYPASS=0, driven with exactly the same inputs as dut_a
//   dut_c  NUM_RD=4, ADDR_W=4, DATA_W=16 for packed-slice ordering
// Inputs change at posedge+1; outputs are sampled a further #1 later.
module tb_regs_file_mp;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  regs_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ia ();
  regs_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ib ();
  regs_file_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4)) ic ();

  regs_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  regs_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  regs_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

  // dut_b mirrors every input of dut_a.
  assign ib.wa_en_i    = ia.wa_en_i;
  assign ib.wa_addr_i  = ia.wa_addr_i;
  assign ib.wa_data_i  = ia.wa_data_i;
  assign ib.wb_en_i    = ia.wb_en_i;
  assign ib.wb_addr_i  = ia.wb_addr_i;
  assign ib.wb_data_i  = ia.wb_data_i;
  assign ib.rd_addr_i  = ia.rd_addr_i;
  assign ib.rsv_en_i   = ia.rsv_en_i;
  assign ib.rsv_addr_i = ia.rsv_addr_i;
  assign ib.clr_req_i  = ia.clr_req_i;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ia.wa_en_i    = 1'b0;
    ia.wa_addr_i  = '0;
    ia.wa_data_i  = '0;
    ia.wb_en_i    = 1'b0;
    ia.wb_addr_i  = '0;
    ia.wb_data_i  = '0;
    ia.rsv_en_i   = 1'b0;
    ia.rsv_addr_i = '0;
    ia.clr_req_i  = 1'b0;
  endtask

  task automatic idle_c();
    ic.wa_en_i    = 1'b0;
    ic.wa_addr_i  = '0;
    ic.wa_data_i  = '0;
    ic.wb_en_i    = 1'b0;
    ic.wb_addr_i  = '0;
    ic.wb_data_i  = '0;
    ic.rsv_en_i   = 1'b0;
    ic.rsv_addr_i = '0;
    ic.clr_req_i  = 1'b0;
  endtask

  initial begin
    idle_a();
    idle_c();
    ia.rd_addr_i = '0;
    ic.rd_addr_i = '0;

    // ---- reset: outputs held at zero even with a write presented
    #1 rst_n = 1'b0;
    ia.wa_en_i   = 1'b1;
    ia.wa_addr_i = 5'd5;
    ia.wa_data_i = 32'hCAFE_F00D;
    ia.rd_addr_i = {5'd5, 5'd5};
    #2;
    chk("rst_rd_a",     ia.rd_data_o,   64'h0);
    chk("rst_rd_b",     ib.rd_data_o,   64'h0);
    chk("rst_busy",     ia.rd_busy_o,   64'h0);
    chk("rst_clr_busy", ia.clr_busy_o,  64'h0);
    chk("rst_clr_done", ia.clr_done_o,  64'h0);
    chk("rst_state",    ia.clr_state_o, 64'h0);
    idle_a();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // ---- basic write / read, same-cycle bypass vs no bypass
    ia.wa_en_i   = 1'b1;
    ia.wa_addr_i = 5'd5;
    ia.wa_data_i = 32'hDEAD_BEEF;
    ia.rd_addr_i = {5'd0, 5'd5};
    #1;
    chk("byp_a_addr5",   ia.rd_data_o[31:0], 64'hDEAD_BEEF);
    chk("nobyp_b_addr5", ib.rd_data_o[31:0], 64'h0);
    tick(); idle_a(); #1;
    chk("rd_a_addr5", ia.rd_data_o[31:0], 64'hDEAD_BEEF);
    chk("rd_b_addr5", ib.rd_data_o[31:0], 64'hDEAD_BEEF);

    // ---- write to register 0 is dropped and never bypassed
    ia.wa_en_i   = 1'b1;
    ia.wa_addr_i = 5'd0;
    ia.wa_data_i = 32'h0000_1234;
    ia.rd_addr_i = {5'd5, 5'd0};
    #1;
    chk("byp_a_addr0", ia.rd_data_o[31:0], 64'h0);
    tick(); idle_a(); #1;
    chk("rd_a_addr0", ia.rd_data_o[31:0], 64'h0);
    chk("rd_b_addr0", ib.rd_data_o[31:0], 64'h0);

    // ---- A and B to the same address: B wins (bypass and storage)
    ia.wa_en_i   = 1'b1; ia.wa_addr_i = 5'd7; ia.wa_data_i = 32'h11;
    ia.wb_en_i   = 1'b1; ia.wb_addr_i = 5'd7; ia.wb_data_i = 32'h22;
    ia.rd_addr_i = {5'd7, 5'd5};
    #1;
    chk("byp_a_ab7",   ia.rd_data_o[63:32], 64'h22);
    chk("nobyp_b_ab7", ib.rd_data_o[63:32], 64'h0);
    tick(); idle_a(); #1;
    chk("rd_a_ab7", ia.rd_data_o[63:32], 64'h22);
    chk("rd_b_ab7", ib.rd_data_o[63:32], 64'h22);

    // ---- A and B to different addresses: both land, port order checked
    ia.wa_en_i   = 1'b1; ia.wa_addr_i = 5'd10; ia.wa_data_i = 32'hA;
    ia.wb_en_i   = 1'b1; ia.wb_addr_i = 5'd11; ia.wb_data_i = 32'hB;
    ia.rd_addr_i = {5'd11, 5'd10};
    tick(); idle_a(); #1;
    chk("rd_a_ab_distinct", ia.rd_data_o, {32'h0000_000B, 32'h0000_000A});
    chk("rd_b_ab_distinct", ib.rd_data_o, {32'h0000_000B, 32'h0000_000A});

    // ---- scoreboard
    ia.rsv_en_i   = 1'b1;
    ia.rsv_addr_i = 5'd3;
    ia.rd_addr_i  = {5'd5, 5'd3};
    #1;
    chk("busy_before_rsv", ia.rd_busy_o, 64'h0);
    tick(); idle_a(); #1;
    chk("busy_a_rsv3", ia.rd_busy_o, 64'h1);
    chk("busy_b_rsv3", ib.rd_busy_o, 64'h1);
    ia.wb_en_i   = 1'b1; ia.wb_addr_i = 5'd3; ia.wb_data_i = 32'h33;
    #1;
    chk("busy_not_bypassed", ia.rd_busy_o,       64'h1);
    chk("byp_a_wb3",         ia.rd_data_o[31:0], 64'h33);
    chk("nobyp_b_wb3",       ib.rd_data_o[31:0], 64'h0);
    tick(); idle_a(); #1;
    chk("busy_cleared_wb3", ia.rd_busy_o,       64'h0);
    chk("rd_a_wb3",         ia.rd_data_o[31:0], 64'h33);
    ia.rsv_en_i  = 1'b1; ia.rsv_addr_i = 5'd3;
    ia.wa_en_i   = 1'b1; ia.wa_addr_i  = 5'd3; ia.wa_data_i = 32'h44;
    tick(); idle_a(); #1;
    chk("busy_rsv_wins", ia.rd_busy_o,       64'h1);
    chk("rd_a_rsv_wr3",  ia.rd_data_o[31:0], 64'h44);

    // ---- preload 1..31, reserve 20, then a full clear
    for (int i = 1; i < 32; i++) begin
      ia.wa_en_i   = 1'b1;
      ia.wa_addr_i = 5'(i);
      ia.wa_data_i = 32'h100 + 32'(i);
      tick();
    end
    idle_a();
    ia.rsv_en_i = 1'b1; ia.rsv_addr_i = 5'd20;
    tick(); idle_a();
    ia.rd_addr_i = {5'd20, 5'd1};
    #1;
    chk("preload_rd",   ia.rd_data_o, {32'h0000_0114, 32'h0000_0101});
    chk("preload_busy", ia.rd_busy_o, 64'h2);

    ia.clr_req_i = 1'b1;
    tick(); idle_a();
    for (int c = 1; c <= 32; c++) begin
      #1;
      chk($sformatf("clr_busy_c%0d", c), ia.clr_busy_o, 64'h1);
      chk($sformatf("clr_done_c%0d", c), ia.clr_done_o, 64'h0);
      if (c == 5) begin
        // addresses 0..3 swept so far; 31 untouched
        ia.rd_addr_i = {5'd31, 5'd1};
        #1;
        chk("clr_partial", ia.rd_data_o, {32'h0000_011F, 32'h0000_0000});
      end
      if (c == 10) begin
        // write, reserve and a new request during the sweep are all dropped
        ia.wa_en_i   = 1'b1; ia.wa_addr_i  = 5'd2; ia.wa_data_i = 32'hBAD;
        ia.rsv_en_i  = 1'b1; ia.rsv_addr_i = 5'd2;
        ia.clr_req_i = 1'b1;
        ia.rd_addr_i = {5'd2, 5'd2};
        #1;
        chk("clr_no_bypass", ia.rd_data_o[31:0], 64'h0);
      end
      tick(); idle_a();
    end
    #1;
    chk("clr_busy_done", ia.clr_busy_o,  64'h0);
    chk("clr_done_33",   ia.clr_done_o,  64'h1);
    chk("clr_state_done", ia.clr_state_o, 64'h2);
    tick(); #1;
    chk("clr_done_drop", ia.clr_done_o,  64'h0);
    chk("clr_state_idle", ia.clr_state_o, 64'h0);
    for (int i = 0; i < 32; i += 2) begin
      ia.rd_addr_i = {5'(i + 1), 5'(i)};
      #1;
      chk($sformatf("clr_rd_a_%0d", i),   ia.rd_data_o, 64'h0);
      chk($sformatf("clr_rd_b_%0d", i),   ib.rd_data_o, 64'h0);
      chk($sformatf("clr_busy_a_%0d", i), ia.rd_busy_o, 64'h0);
    end

    // ---- reset asserted at clear cycle 10
    tick();
    ia.wa_en_i = 1'b1; ia.wa_addr_i = 5'd30; ia.wa_data_i = 32'h30;
    tick(); idle_a();
    ia.clr_req_i = 1'b1;
    tick(); idle_a();
    repeat (9) tick();
    ia.rd_addr_i = {5'd30, 5'd30};
    #1;
    chk("midclr_pre_rst", ia.rd_data_o[31:0], 64'h30);
    chk("midclr_busy",    ia.clr_busy_o,      64'h1);
    rst_n = 1'b0;
    #1;
    chk("midclr_rst_rd",    ia.rd_data_o,   64'h0);
    chk("midclr_rst_busy",  ia.rd_busy_o,   64'h0);
    chk("midclr_rst_clrb",  ia.clr_busy_o,  64'h0);
    chk("midclr_rst_done",  ia.clr_done_o,  64'h0);
    chk("midclr_rst_state", ia.clr_state_o, 64'h0);
    repeat (2) begin
      tick();
      chk("midclr_hold_done", ia.clr_done_o, 64'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      chk($sformatf("post_rst_done_%0d", c), ia.clr_done_o, 64'h0);
      chk($sformatf("post_rst_clrb_%0d", c), ia.clr_busy_o, 64'h0);
    end
    chk("post_rst_rd30", ia.rd_data_o[31:0], 64'h0);
    ia.wa_en_i = 1'b1; ia.wa_addr_i = 5'd9; ia.wa_data_i = 32'h99;
    tick(); idle_a();
    ia.rd_addr_i = {5'd9, 5'd9};
    #1;
    chk("post_rst_rd9_a", ia.rd_data_o[31:0], 64'h99);
    chk("post_rst_rd9_b", ib.rd_data_o[63:32], 64'h99);

    // ---- four read ports on dut_c, packed slice ordering
    for (int i = 1; i <= 4; i++) begin
      ic.wa_en_i   = 1'b1;
      ic.wa_addr_i = 4'(i);
      ic.wa_data_i = 16'(16'h1111 * i);
      tick();
    end
    idle_c();
    ic.rsv_en_i = 1'b1; ic.rsv_addr_i = 4'd4;
    tick(); idle_c();
    // port0=3, port1=1, port2=4, port3=2
    ic.rd_addr_i = {4'd2, 4'd4, 4'd1, 4'd3};
    #1;
    chk("c_rd4", ic.rd_data_o, {16'h2222, 16'h4444, 16'h1111, 16'h3333});
    chk("c_busy4", ic.rd_busy_o, 64'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regs_file_mp.md
Name: regs_file_mp

Overview:
Parametrised general-purpose register file for the rooth core. It generalises the 2-read/1-write file to NUM_RD read ports and two prioritised write ports (ALU writeback A, load writeback B). It adds optional write-to-read bypass, a per-register busy scoreboard for hazard detection, and a sequential clear engine. It sits between decode (reads, reservations) and writeback (writes).

Parameters:
DATA_W, 32, register/data width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of combinational read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
wa_en_i  in  1  write port A enable
wa_addr_i  in  ADDR_W  write port A address
wa_data_i  in  DATA_W  write port A data
wb_en_i  in  1  write port B enable
wb_addr_i  in  ADDR_W  write port B address
wb_data_i  in  DATA_W  write port B data
rd_addr_i  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data_o  out  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W]
rd_busy_o  out  NUM_RD  busy flag of each addressed register
rsv_en_i  in  1  reserve (mark busy) a destination register
rsv_addr_i  in  ADDR_W  register to reserve
clr_req_i  in  1  request sequential clear of whole file
clr_busy_o  out  1  clear engine active
clr_done_o  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset (rst_n low, async): all DEPTH registers = 0, all busy bits = 0, FSM = IDLE, clr_busy_o = 0, clr_done_o = 0. While rst_n is low, rd_data_o = 0 and rd_busy_o = 0.
- Writes are synchronous on posedge clk.
  - A and B to different addresses: both write.
  - Same address: B wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads are combinational (0-cycle latency). Address 0 with ZERO_REG=1 reads 0, busy 0.
- BYPASS=1: if a write enable is active to the read address this cycle, rd_data returns that write data (B over A). The bypass never applies to address 0 when ZERO_REG=1.
- BYPASS=0: a read returns the pre-edge stored value.
- Scoreboard, updated on posedge:
  - rsv_en_i sets busy[rsv_addr_i].
  - Any accepted write clears busy[addr].
  - Reserve and write to the same address in the same cycle: busy ends at 1 (new reservation wins).
  - rd_busy_o reflects the registered busy bits. It is not bypassed by a same-cycle write.
- Clear FSM:
  - IDLE: clr_req_i=1 -> CLEAR with idx=0.
  - CLEAR: each cycle, register[idx] <= 0 and busy[idx] <= 0, then idx++.
    - When idx == DEPTH-1 -> DONE.
    - clr_busy_o = 1 throughout CLEAR.
    - wa/wb writes and rsv_en_i are ignored (dropped, not queued).
    - clr_req_i is ignored.
    - Reads still return array contents, partially cleared.
  - DONE: clr_done_o = 1 for exactly one cycle, clr_busy_o = 0, -> IDLE.
  - A full clear takes DEPTH cycles in CLEAR. clr_done_o fires DEPTH+1 cycles after the request edge.
- Reset asserted mid-clear: immediate return to IDLE with everything zero. No clr_done_o pulse.
- Idx counter is ADDR_W bits wide and never wraps past DEPTH-1.

Test Plan:
- Write A addr 5 = 0xDEADBEEF; next cycle read port0 addr 5 -> 0xDEADBEEF. Write A addr 0 = 0x1234 -> read addr 0 stays 0.
- A and B both write addr 7 (A=0x11, B=0x22), BYPASS=1 -> same-cycle read of 7 returns 0x22, stored value 0x22. With BYPASS=0 the same-cycle read returns the old value (0).
- rsv addr 3 -> rd_busy for addr 3 = 1 next cycle. B write addr 3 -> busy 0 next cycle. Reserve + write addr 3 same cycle -> busy stays 1.
- Preload regs 1..31 nonzero, pulse clr_req_i -> clr_busy_o high 32 cycles, clr_done_o single pulse at cycle 33. All reads 0, all busy 0. A write issued mid-clear is dropped.
- Assert rst_n low at clear cycle 10 -> outputs zero immediately, FSM IDLE, no clr_done_o. After release, a normal write/read of addr 9 works.
- NUM_RD=4, ADDR_W=4: four distinct addresses read simultaneously -> each port returns its own data. Packed-slice ordering is checked.
